alu_pipe: RTL and testbench

//  Parametrised, handshaked successor to the single-cycle EX-stage ALU: WIDTH-bit datapath, registered

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_seq.sv | 49 ++++
 rtl/alu_pipe.sv | 140 ++++++++++++++
 tb/tb_alu_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode values and controller state encoding for the pipelined EX-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_INC = 4'b0110;
  localparam logic [3:0] ALU_DEC = 4'b0111;
  localparam logic [3:0] ALU_NOT = 4'b1000;
  localparam logic [3:0] ALU_MUL = 4'b1001;
  localparam logic [3:0] ALU_SLT = 4'b1010;
  localparam logic [3:0] ALU_SLL = 4'b1011;
  localparam logic [3:0] ALU_SRL = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  // Ops whose carry/overflow flags are meaningful.
  function automatic logic is_arith(input logic [3:0] op);
    return op inside {ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC};
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier producing the low WIDTH bits of an unsigned product.
// Bit 0 is folded in at start; the remaining WIDTH-1 bits take one cycle each.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  // High during the cycle that folds in the last multiplier bit.
  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign busy    = busy_q;
  assign product = acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= a << 1;
      b_q    <= b >> 1;
      acc_q  <= b[0] ? a : '0;
      cnt_q  <= CW'(1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (b_q[0]) acc_q <= acc_q + a_q;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked EX-stage ALU: single-cycle ops land in the output register on accept,
// MUL runs on the sequential multiplier and loads the output register when it is free.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_con,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             alu_error
);

  localparam int unsigned SW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic             accept, is_mul, out_free, load_single, load_mul;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product, b_op, alu_res;
  logic             cin, alu_err;
  logic [WIDTH:0]   sum;
  logic [SW-1:0]    shamt;

  assign is_mul   = MUL_EN && (alu_con == ALU_MUL);
  assign out_free = !out_valid || out_ready;
  assign in_ready = (state_q == S_IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign shamt    = data_b[SW-1:0];

  // One shared adder: SUB/DEC are A plus the complemented/all-ones operand.
  always_comb begin
    b_op = '0;
    cin  = 1'b0;
    case (alu_con)
      ALU_ADD: b_op = data_b;
      ALU_SUB: begin
        b_op = ~data_b;
        cin  = 1'b1;
      end
      ALU_INC: cin = 1'b1;
      ALU_DEC: b_op = '1;
      default: ;
    endcase
  end

  assign sum = {1'b0, data_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (alu_con)
      ALU_AND:                          alu_res = data_a & data_b;
      ALU_OR:                           alu_res = data_a | data_b;
      ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC: alu_res = sum[WIDTH-1:0];
      ALU_NOR:                          alu_res = ~(data_a | data_b);
      ALU_XOR:                          alu_res = data_a ^ data_b;
      ALU_NOT:                          alu_res = ~data_a;
      ALU_MUL:                          alu_err = !MUL_EN;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(data_a) < $signed(data_b)};
      ALU_SLL:                          alu_res = data_a << shamt;
      ALU_SRL:                          alu_res = data_a >> shamt;
      default:                          alu_err = 1'b1;
    endcase
  end

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && is_mul),
    .a       (data_a),
    .b       (data_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (mul_done) state_d = S_DONE;
      S_DONE:  if (!mul_busy && out_free) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign load_single = accept && !is_mul;
  assign load_mul    = (state_q == S_DONE) && !mul_busy && out_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      alu_error <= 1'b0;
    end else if (load_single) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      zero      <= (alu_res == '0);
      negative  <= alu_res[WIDTH-1];
      carry     <= is_arith(alu_con) && sum[WIDTH];
      overflow  <= is_arith(alu_con) && (data_a[WIDTH-1] == b_op[WIDTH-1]) &&
                   (sum[WIDTH-1] != data_a[WIDTH-1]);
      alu_error <= alu_err;
    end else if (load_mul) begin
      out_valid <= 1'b1;
      result    <= mul_product;
      zero      <= (mul_product == '0);
      negative  <= mul_product[WIDTH-1];
      carry     <= 1'b0;
      overflow  <= 1'b0;
      alu_error <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes model results on accept, monitor pops and
// checks values, latency, in_ready and hold-stability whenever the DUT presents a result.
module tb_alu_pipe;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   alu_con;
  logic [W-1:0] data_a, data_b, result;
  logic         zero, negative, carry, overflow, alu_error;

  alu_pipe #(
    .WIDTH  (W),
    .MUL_EN (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_con   (alu_con),
    .data_a    (data_a),
    .data_b    (data_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow),
    .alu_error (alu_error)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z, n, cy, ov, err;
    int           acc;
    bit           is_mul;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   hold_cnt = 0;
  bit   mul_out = 1'b0;
  bit   free_hist[int];
  bit   pv = 1'b0, pr = 1'b0;
  logic [63:0] pbus;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference behaviour from plain wide arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    longint          sa = $signed(a);
    longint          sbv = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          sr = 0;
    bit              arith = 1'b0;
    logic [4:0]      sh = b[4:0];
    e.res = '0; e.cy = 1'b0; e.ov = 1'b0; e.err = 1'b0; e.acc = 0; e.is_mul = 1'b0;
    case (op)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: begin e.res = W'(ua + ub); e.cy = (ua + ub) > 64'hFFFF_FFFF; sr = sa + sbv; arith = 1; end
      4'h3: begin e.res = W'(ua - ub); e.cy = (ua >= ub); sr = sa - sbv; arith = 1; end
      4'h4: e.res = ~(a | b);
      4'h5: e.res = a ^ b;
      4'h6: begin e.res = W'(ua + 1); e.cy = (ua == 64'hFFFF_FFFF); sr = sa + 1; arith = 1; end
      4'h7: begin e.res = W'(ua - 1); e.cy = (ua != 0); sr = sa - 1; arith = 1; end
      4'h8: e.res = ~a;
      4'h9: e.res = W'(ua * ub);
      4'hA: e.res = (sa < sbv) ? 1 : 0;
      4'hB: e.res = a << sh;
      4'hC: e.res = a >> sh;
      default: e.err = 1'b1;
    endcase
    if (arith) e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.z = (e.res == 0);
    e.n = e.res[W-1];
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int   waited = 0;
    int   c = 0;
    bit   ok = 1'b0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; alu_con = op; data_a = a; data_b = b;
    forever begin
      #4;
      c  = cyc;
      ok = in_ready;
      @(posedge clk);
      if (ok || waited > 200) break;
      waited++;
      @(negedge clk);
    end
    if (ok) begin
      e = model(op, a, b);
      e.acc = c;
      e.is_mul = (op == 4'h9);
      sb.push_back(e);
      if (e.is_mul) mul_out = 1'b1;
    end else begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: actual no accept required accept of op %0h", op);
    end
    #1;
    in_valid = 1'b0; alu_con = 4'($urandom); data_a = $urandom; data_b = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 2000) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: actual %0d pending required 0", sb.size());
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: drives out_ready, then samples just before the next rising edge.
  initial begin : monitor
    exp_t        e;
    logic [63:0] bus;
    bit          freec, newp;
    int          d, expc;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (hold_cnt > 0) begin
          out_ready = 1'b0; hold_cnt--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        #4;
        bus   = {27'd0, result, zero, negative, carry, overflow, alu_error};
        freec = !out_valid || out_ready;
        free_hist[cyc] = freec;
        newp  = out_valid && (!pv || pr);
        if (out_valid && pv && !pr) check("hold_stable", bus, pbus);
        if (pv && !pr) check("hold_valid", 64'(out_valid), 64'd1);
        if (newp) begin
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_output: actual %0h required none", result);
          end else begin
            e = sb.pop_front();
            check("result_flags", bus, {27'd0, e.res, e.z, e.n, e.cy, e.ov, e.err});
            if (e.is_mul) begin
              d = e.acc + W;
              while (d < cyc && !(free_hist.exists(d) && free_hist[d])) d++;
              expc = d + 1;
              mul_out = 1'b0;
            end else begin
              expc = e.acc + 1;
            end
            check("latency", 64'(cyc), 64'(expc));
          end
        end
        check("in_ready", 64'(in_ready), 64'(!mul_out && freec));
        pv = out_valid; pr = out_ready; pbus = bus;
      end
    end
  end

  initial begin
    int bad;
    logic [3:0] op;
    reset = 1'b1; in_valid = 1'b0; alu_con = '0; data_a = '0; data_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", {27'd0, result, zero, negative, carry, overflow, alu_error}, 64'd0);
    @(negedge clk); reset = 1'b0;
    #4;
    check("ready_after_reset", 64'(in_ready), 64'd1);
    pv = 1'b0; pr = 1'b0; mon_en = 1'b1;

    issue(4'h2, 32'h7FFF_FFFF, 32'd1);
    issue(4'h3, 32'd5, 32'd5);
    issue(4'h3, 32'd0, 32'd1);
    issue(4'h9, 32'd1234, 32'd5678);
    issue(4'h0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    drain();

    // Stalled consumer: AND held for 5 cycles while XOR waits.
    hold_cnt = 6;
    issue(4'h0, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
    issue(4'h5, 32'h1234_5678, 32'hFFFF_0000);
    issue(4'hE, 32'h1111_1111, 32'h2222_2222);
    issue(4'hD, 32'd7, 32'd9);
    issue(4'hF, 32'd0, 32'd0);
    drain();

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'h9 && $urandom_range(0, 3) != 0) op = 4'h2;
      issue(op, rnd_val(), rnd_val());
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    drain();

    // Asynchronous reset with a result pending in the output register.
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    issue(4'h2, 32'd2, 32'd3);
    #2 reset = 1'b1;
    #1;
    check("async_reset_valid", 64'(out_valid), 64'd0);
    check("async_reset_outputs", {27'd0, result, zero, negative, carry, overflow, alu_error},
          64'd0);
    @(negedge clk); reset = 1'b0;
    #4;
    check("ready_after_async_reset", 64'(in_ready), 64'd1);
    sb.delete(); mul_out = 1'b0;

    // Reset part-way through a multiply must discard it.
    issue(4'h9, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mul_reset_valid", 64'(out_valid), 64'd0);
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    check("no_output_after_mul_reset", 64'(bad), 64'd0);
    check("ready_after_mul_reset", 64'(in_ready), 64'd1);
    sb.delete(); mul_out = 1'b0; hold_cnt = 0; pv = 1'b0; pr = 1'b0;
    mon_en = 1'b1;
    issue(4'h2, 32'd2, 32'd3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
